// File: rtl/qed_check_ctrl.sv
// QED consistency-check controller: once original and duplicate retire counts
// match and the pipe drains, compare register j against its pair j+16 for j=1..15.
module qed_check_ctrl #(
  parameter int DATA_W = 72,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              check_mode,
  input  logic              orig_commit,
  input  logic              dup_commit,
  input  logic              pipe_idle,
  output logic              rd_req,
  output logic [4:0]        rd_addr,
  input  logic              rd_gnt,
  input  logic [DATA_W-1:0] rd_data,
  input  logic              clr_fail,
  output logic              chk_busy,
  output logic              cmp_valid,
  output logic              chk_done,
  output logic              chk_fail,
  output logic [3:0]        fail_idx
);

  // Read handshake: rd_req/rd_addr are held until rd_gnt is seen high in the
  // same cycle; rd_data is sampled exactly one cycle after that grant.
  typedef enum logic [2:0] {IDLE, REQ_LO, CAP_LO, REQ_HI, CAP_HI, DONE} state_t;

  state_t             state, state_nx;
  logic [CNT_W-1:0]   orig_cnt, dup_cnt, last_cnt;
  logic [3:0]         j, j_nx;
  logic [DATA_W-1:0]  lo_reg;
  logic               start, mismatch, fail_set;

  assign start    = check_mode && pipe_idle && (orig_cnt == dup_cnt) &&
                    (orig_cnt != '0) && (orig_cnt != last_cnt);
  assign mismatch = (state == CAP_HI) && check_mode && (rd_data != lo_reg);
  // A fresh mismatch beats a simultaneous clear, so it may re-arm the flag.
  assign fail_set = mismatch && (!chk_fail || clr_fail);

  always_comb begin
    state_nx = state;
    j_nx     = j;
    if (state != IDLE && !check_mode) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state_nx = REQ_LO;
            j_nx     = 4'd1;
          end
        end
        REQ_LO:  if (rd_gnt) state_nx = CAP_LO;
        CAP_LO:  state_nx = REQ_HI;
        REQ_HI:  if (rd_gnt) state_nx = CAP_HI;
        CAP_HI: begin
          if (j == 4'd15) begin
            state_nx = DONE;
          end else begin
            state_nx = REQ_LO;
            j_nx     = j + 4'd1;
          end
        end
        DONE:    state_nx = IDLE;
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      j         <= '0;
      lo_reg    <= '0;
      rd_req    <= 1'b0;
      rd_addr   <= '0;
      chk_busy  <= 1'b0;
      cmp_valid <= 1'b0;
      chk_done  <= 1'b0;
      chk_fail  <= 1'b0;
      fail_idx  <= '0;
    end else begin
      state     <= state_nx;
      j         <= j_nx;
      if (state == CAP_LO) lo_reg <= rd_data;
      // Outputs are registered from the next state so they line up with it.
      rd_req    <= (state_nx == REQ_LO) || (state_nx == REQ_HI);
      rd_addr   <= (state_nx == REQ_LO) ? {1'b0, j_nx} :
                   (state_nx == REQ_HI) ? {1'b1, j_nx} : 5'd0;
      chk_busy  <= (state_nx != IDLE);
      cmp_valid <= (state_nx == CAP_HI);
      chk_done  <= (state_nx == DONE);
      if (fail_set) begin
        chk_fail <= 1'b1;
        fail_idx <= j;
      end else if (clr_fail) begin
        chk_fail <= 1'b0;
        fail_idx <= '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      orig_cnt <= '0;
      dup_cnt  <= '0;
      last_cnt <= '0;
    end else if (!check_mode) begin
      orig_cnt <= '0;
      dup_cnt  <= '0;
      last_cnt <= '0;
    end else begin
      if (orig_commit) orig_cnt <= orig_cnt + CNT_W'(1);
      if (dup_commit)  dup_cnt  <= dup_cnt + CNT_W'(1);
      if (state == DONE) last_cnt <= orig_cnt;
    end
  end

endmodule

// File: doc/qed_check_ctrl.md
QED_CHECK_CTRL -- requirements
Module: qed_check_ctrl

Interface
REQ-001: Parameter DATA_W, default 72, is the register word width.
REQ-002: Parameter CNT_W, default 16, is the width of the commit counters.
REQ-003: The block SHALL have one clock and an asynchronous, active-low reset; the ports are named clk and rst.
REQ-004: Ports (name  direction  width  meaning) SHALL be:
- clk  in  1  clock
- rst  in  1  async active-low reset
- check_mode  in  1  QED in CHECK mode
- orig_commit  in  1  original instruction retired this cycle
- dup_commit  in  1  duplicate instruction retired this cycle
- pipe_idle  in  1  no instruction in flight
- rd_req  out  1  register read request
- rd_addr  out  5  register index
- rd_gnt  in  1  read accepted this cycle
- rd_data  in  DATA_W  read data, valid the cycle after rd_gnt
- clr_fail  in  1  clear sticky failure
- chk_busy  out  1  scan in progress
- cmp_valid  out  1  pair comparison performed this cycle
- chk_done  out  1  one-cycle scan-complete pulse
- chk_fail  out  1  sticky mismatch flag
- fail_idx  out  4  lowest mismatching pair index j

Function
REQ-005: orig_cnt and dup_cnt SHALL each increment by 1 on their commit input, both in the same cycle if both are asserted, independent of FSM state, wrapping modulo 2^CNT_W.
REQ-006: While check_mode=0, orig_cnt, dup_cnt and last_cnt SHALL be held at 0.
REQ-007: FSM states SHALL be IDLE, REQ_LO, CAP_LO, REQ_HI, CAP_HI, DONE.
REQ-008: IDLE -> REQ_LO with j=1 SHALL occur when all of the following hold: check_mode=1, pipe_idle=1, orig_cnt==dup_cnt, orig_cnt!=0, orig_cnt!=last_cnt.
REQ-009: In REQ_LO, rd_req=1 and rd_addr=j SHALL be driven, held stable until rd_gnt; on rd_gnt the FSM SHALL go to CAP_LO.
REQ-010: CAP_LO SHALL latch rd_data into lo_reg and go to REQ_HI.
REQ-011: REQ_HI SHALL behave as REQ_LO with rd_addr=j+16, then go to CAP_HI on rd_gnt.
REQ-012: CAP_HI SHALL assert cmp_valid and compare rd_data against lo_reg over the full DATA_W.
- On mismatch with chk_fail=0: set chk_fail=1 and fail_idx=j.
- If j==15, go to DONE; else increment j and go to REQ_LO.
REQ-013: DONE SHALL assert chk_done for one cycle, load last_cnt with orig_cnt, and return to IDLE.
REQ-014: chk_busy SHALL be 1 in every state except IDLE.
REQ-015: rd_req SHALL be 0 outside REQ_LO and REQ_HI.
REQ-016: With rd_gnt tied high, the scan SHALL take 4 cycles per pair; chk_done SHALL be high exactly 61 cycles after the IDLE trigger cycle.
REQ-017: If check_mode falls in any non-IDLE state, the FSM SHALL return to IDLE the next cycle with no chk_done, no chk_fail or fail_idx update, and no last_cnt update.
REQ-018: Once set, chk_fail and fail_idx SHALL hold until clr_fail or reset; a later mismatch SHALL not overwrite them.
REQ-019: clr_fail SHALL clear chk_fail and fail_idx; if clr_fail and a new mismatch occur in the same cycle, the mismatch SHALL win.
REQ-020: Register 0 and its pair register 16 SHALL never be read.

Reset
REQ-021: While rst=0, the block SHALL be in IDLE with all counters, j, lo_reg, last_cnt and all outputs at 0.
REQ-022: Reset asserted mid-scan SHALL abort immediately, with no chk_done pulse.

Verification
REQ-023: rd_gnt=1, 5 orig and 5 dup commits, pipe_idle=1, all pairs equal -> rd_addr sequence 1,17,2,18,…,15,31; chk_done at trigger+61; chk_fail=0.
REQ-024: reg 7 != reg 23 and reg 12 != reg 28 -> chk_fail=1, fail_idx=7 after the scan; a second scan leaves fail_idx=7.
REQ-025: orig_cnt=3, dup_cnt=2 -> no scan; one dup_commit -> scan starts; with no further commits, no re-scan after chk_done.
REQ-026: rd_gnt low 3 cycles on the first request -> rd_req and rd_addr=1 held 4 cycles; total latency +3.
REQ-027: check_mode drops during pair 9 -> IDLE next cycle, no chk_done, counters cleared.
REQ-028: orig_cnt and dup_cnt at 0xFFFF, simultaneous commits -> both wrap to 0 and no scan triggers (REQ-008); clr_fail pulse -> chk_fail=0.
